// File: rtl/counter_down_timer_t_pkg.sv
// Shared types and constants for the loadable down-counting timer:
// FSM state encoding and active-low 7-segment patterns (segments a..g, a is MSB).
package counter_down_timer_t_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned SEG_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/counter_down_timer_t_if.sv
// Control/status bundle of the down-counting timer; master drives controls, slave is the timer.
interface counter_down_timer_t_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic             start;
  logic             enable;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             done;
  logic [0:6]       hex;

  modport master (output load, start, enable, d, input q, zero, done, hex);
  modport slave  (input load, start, enable, d, output q, zero, done, hex);
endinterface

// File: rtl/counter_down_timer_t_tff.sv
// T flip-flop with asynchronous active-high clear; one bit of the timer count.
module t_ff_areset_h (
  input  logic clk,
  input  logic aclr,
  input  logic t,
  output logic q
);
  logic q_q, q_d;

  always_comb q_d = q_q ^ t;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) q_q <= 1'b0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/counter_down_timer_t.sv
// Loadable down-counting timer on T flops with IDLE/ARMED/RUN/DONE control and HEX output.
// Define COUNTDOWN_AUTORELOAD_EN to reload and keep running at terminal count.
module counter_down_timer_t
  import counter_down_timer_t_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   aclr,
  counter_down_timer_t_if.slave  bus
);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] t_c;
  logic [WIDTH-1:0] dec_t_c;
  logic             cnt_en_c;
  logic [SEG_W-1:0] hex_c;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    t_ff_areset_h u_tff (
      .clk  (clk),
      .aclr (aclr),
      .t    (t_c[i]),
      .q    (cnt_q[i])
    );
  end

  // Ripple-borrow toggle enables: a bit flips when every lower bit is zero.
  always_comb begin
    logic low_zero;
    cnt_en_c = (state_q == S_RUN) & bus.enable & ~bus.load;
    dec_t_c  = '0;
    low_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      dec_t_c[i] = cnt_en_c & low_zero;
      low_zero   = low_zero & ~cnt_q[i];
    end
  end

  // Next state, done pulse and toggle vector; load overrides everything.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    t_c      = dec_t_c;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      state_d = S_ARMED;
      t_c     = cnt_q ^ bus.d;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_d = bus.d;
`endif
    end else begin
      case (state_q)
        S_ARMED: begin
          if (bus.start) begin
            if (cnt_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.enable && cnt_q == WIDTH'(1)) begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            t_c    = cnt_q ^ reload_q;
`else
            state_d = S_DONE;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    case (cnt_q[3:0])
      4'h0:    hex_c = SEG_0;
      4'h1:    hex_c = SEG_1;
      4'h2:    hex_c = SEG_2;
      4'h3:    hex_c = SEG_3;
      4'h4:    hex_c = SEG_4;
      4'h5:    hex_c = SEG_5;
      4'h6:    hex_c = SEG_6;
      4'h7:    hex_c = SEG_7;
      4'h8:    hex_c = SEG_8;
      4'h9:    hex_c = SEG_9;
      4'hA:    hex_c = SEG_A;
      4'hB:    hex_c = SEG_B;
      4'hC:    hex_c = SEG_C;
      4'hD:    hex_c = SEG_D;
      4'hE:    hex_c = SEG_E;
      default: hex_c = SEG_F;
    endcase
  end

  assign bus.q    = cnt_q;
  assign bus.zero = (cnt_q == '0);
  assign bus.done = done_q;
  assign bus.hex  = hex_c;

endmodule
